// File: rtl/lsu_arb_pkg.sv
// Shared types and defaults for the two-port LSU arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  typedef enum logic {
    P0 = 1'b0,
    P1 = 1'b1
  } port_e;

  localparam int LSU_ARB_MAX_BURST_DEF = 4;

  // Burst counter width; holds MAX_BURST values up to 15.
  localparam int LSU_ARB_CNT_W = 4;

endpackage

// File: rtl/lsu_arb_pick.sv
// Combinational round-robin winner pick with a bounded burst length.
// Latency: 0 cycles (pure combinational).
// Backpressure: a losing requester gets no winner slot and must hold its request.
//
// Ports:
//   i_owner, i_cnt, i_last : registered arbiter state
//   i_req0, i_req1         : current requests (already masked by reset)
//   o_win_vld, o_win       : a winner exists / which port it is
module lsu_arb_pick
  import lsu_arb_pkg::*;
#(
  parameter int MAX_BURST = LSU_ARB_MAX_BURST_DEF
) (
  input  owner_e                   i_owner,
  input  logic [LSU_ARB_CNT_W-1:0] i_cnt,
  input  port_e                    i_last,
  input  logic                     i_req0,
  input  logic                     i_req1,
  output logic                     o_win_vld,
  output port_e                    o_win
);

  localparam logic [LSU_ARB_CNT_W-1:0] MAX_B = LSU_ARB_CNT_W'(MAX_BURST);

  always_comb begin
    o_win_vld = i_req0 | i_req1;
    o_win     = P0;
    if (i_req0 && i_req1) begin
      // Contention: the owner keeps the port until its burst budget is spent.
      // Without an owner, the port not served last goes first.
      unique case (i_owner)
        OWN0:    o_win = (i_cnt < MAX_B) ? P0 : P1;
        OWN1:    o_win = (i_cnt < MAX_B) ? P1 : P0;
        default: o_win = (i_last == P0) ? P1 : P0;
      endcase
    end else if (i_req1) begin
      o_win = P1;
    end
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-port round-robin arbiter in front of the LSU with bounded bursts.
// Latency: grant in the request cycle; load data returns 1 cycle after grant.
// Backpressure: a non-granted requester holds addr/we/wdata until o_gntX.
//
// Ports:
//   i_clk, i_reset                 : clock, synchronous active-high reset
//   i_reqX/i_weX/i_addrX/i_wdataX  : requester X beat (X = 0 core, 1 debug)
//   o_gntX                         : beat accepted this cycle
//   o_rvalidX/o_rdataX             : registered load response to requester X
//   o_lsu_addr/o_st_data/o_lsu_wren: drive to lsu
//   i_ld_data                      : combinational read data from lsu
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = LSU_ARB_MAX_BURST_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [ADDR_W-1:0] o_lsu_addr,
  output logic [DATA_W-1:0] o_st_data,
  output logic              o_lsu_wren,
  input  logic [DATA_W-1:0] i_ld_data
);

  localparam logic [LSU_ARB_CNT_W-1:0] MAX_B = LSU_ARB_CNT_W'(MAX_BURST);

  owner_e                   owner_q, owner_d;
  logic [LSU_ARB_CNT_W-1:0] cnt_q, cnt_d;
  port_e                    last_q, last_d;

  logic  req0_m, req1_m;
  logic  win_vld;
  port_e win;
  logic  win_is_owner;
  logic  ld0, ld1;

  // Requests are ignored while reset is held, so no grant or LSU drive leaks out.
  assign req0_m = i_req0 & ~i_reset;
  assign req1_m = i_req1 & ~i_reset;

  lsu_arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .i_owner   (owner_q),
    .i_cnt     (cnt_q),
    .i_last    (last_q),
    .i_req0    (req0_m),
    .i_req1    (req1_m),
    .o_win_vld (win_vld),
    .o_win     (win)
  );

  assign o_gnt0 = win_vld && (win == P0);
  assign o_gnt1 = win_vld && (win == P1);

  assign win_is_owner = ((owner_q == OWN0) && (win == P0)) ||
                        ((owner_q == OWN1) && (win == P1));

  always_comb begin
    o_lsu_addr = '0;
    o_st_data  = '0;
    o_lsu_wren = 1'b0;
    if (o_gnt0) begin
      o_lsu_addr = i_addr0;
      o_st_data  = i_wdata0;
      o_lsu_wren = i_we0;
    end else if (o_gnt1) begin
      o_lsu_addr = i_addr1;
      o_st_data  = i_wdata1;
      o_lsu_wren = i_we1;
    end
  end

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (win_vld) begin
      last_d = win;
      if (win_is_owner) begin
        // Saturate so a lone streamer yields immediately once the other port asks.
        cnt_d = (cnt_q < MAX_B) ? cnt_q + 1'b1 : cnt_q;
      end else begin
        owner_d = (win == P0) ? OWN0 : OWN1;
        cnt_d   = LSU_ARB_CNT_W'(1);
      end
    end else begin
      owner_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign ld0 = o_gnt0 & ~i_we0;
  assign ld1 = o_gnt1 & ~i_we1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      owner_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= P1;
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
      o_rdata0  <= '0;
      o_rdata1  <= '0;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      o_rvalid0 <= ld0;
      o_rvalid1 <= ld1;
      // Response data is only updated by a load, so it holds across stores/idle.
      if (ld0) o_rdata0 <= i_ld_data;
      if (ld1) o_rdata1 <= i_ld_data;
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
module tb_lsu_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req0, i_req1, i_we0, i_we1;
  logic [31:0] i_addr0, i_addr1, i_wdata0, i_wdata1;
  logic        o_gnt0, o_gnt1, o_rvalid0, o_rvalid1;
  logic [31:0] o_rdata0, o_rdata1, o_lsu_addr, o_st_data;
  logic        o_lsu_wren;
  logic [31:0] ld_data;

  // Second instance with MAX_BURST = 1, sharing the same stimulus.
  logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, wren_b;
  logic [31:0] rdata0_b, rdata1_b, addr_b, st_b;

  // Small lsu model: word RAM plus an LED register at 0x1000_0000.
  logic [31:0] mem [0:63];
  logic [31:0] ledr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  lsu_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req0(i_req0), .i_req1(i_req1), .i_we0(i_we0), .i_we1(i_we1),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_rdata0(o_rdata0), .o_rdata1(o_rdata1), .o_lsu_addr(o_lsu_addr),
    .o_st_data(o_st_data), .o_lsu_wren(o_lsu_wren), .i_ld_data(ld_data)
  );

  lsu_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(1)) dut_b1 (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req0(i_req0), .i_req1(i_req1), .i_we0(i_we0), .i_we1(i_we1),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .o_gnt0(gnt0_b), .o_gnt1(gnt1_b), .o_rvalid0(rvalid0_b), .o_rvalid1(rvalid1_b),
    .o_rdata0(rdata0_b), .o_rdata1(rdata1_b), .o_lsu_addr(addr_b),
    .o_st_data(st_b), .o_lsu_wren(wren_b), .i_ld_data(ld_data)
  );

  assign ld_data = mem[o_lsu_addr[7:2]];

  always @(posedge i_clk) begin
    if (o_lsu_wren) begin
      if (o_lsu_addr == 32'h1000_0000) ledr <= o_st_data;
      else mem[o_lsu_addr[7:2]] <= o_st_data;
    end
  end

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_req0 = 1'b0; i_req1 = 1'b0; i_we0 = 1'b0; i_we1 = 1'b0;
    i_addr0 = '0; i_addr1 = '0; i_wdata0 = '0; i_wdata1 = '0;
  endtask

  task automatic do_reset();
    idle();
    i_reset = 1'b1;
    cycle();
    cycle();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    i_reset = 1'b1;
    cycle();
    cycle();
    // Requests present while reset is held must be ignored.
    i_req0 = 1'b1; i_req1 = 1'b1; i_we0 = 1'b1; i_we1 = 1'b1;
    i_addr0 = 32'h44; i_wdata0 = 32'h1234; i_addr1 = 32'h48; i_wdata1 = 32'h5678;
    #1;
    n_checks++; if (o_gnt0 !== 1'b0 || o_gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b%b want 00", o_gnt0, o_gnt1); end
    n_checks++; if (o_lsu_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b want 0", o_lsu_wren); end
    n_checks++; if (o_lsu_addr !== 32'h0 || o_st_data !== 32'h0) begin n_fail++; $display("FAIL reset_bus: got addr %h data %h want 0/0", o_lsu_addr, o_st_data); end
    n_checks++; if (o_rvalid0 !== 1'b0 || o_rvalid1 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b%b want 00", o_rvalid0, o_rvalid1); end
    n_checks++; if (o_rdata0 !== 32'h0 || o_rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0 0", o_rdata0, o_rdata1); end
    cycle();
    idle();
    i_reset = 1'b0;
    cycle();
  endtask

  task automatic test_single_load();
    idle();
    i_req0 = 1'b1; i_we0 = 1'b1; i_addr0 = 32'h10; i_wdata0 = 32'hDEADBEEF;
    #1;
    n_checks++; if (o_gnt0 !== 1'b1 || o_lsu_wren !== 1'b1 || o_lsu_addr !== 32'h10) begin n_fail++; $display("FAIL setup_store: got gnt %b wren %b addr %h want 1 1 00000010", o_gnt0, o_lsu_wren, o_lsu_addr); end
    cycle();
    i_we0 = 1'b0; i_wdata0 = '0;
    #1;
    n_checks++; if (o_rvalid0 !== 1'b0) begin n_fail++; $display("FAIL store_no_rvalid0: got %b want 0", o_rvalid0); end
    n_checks++; if (o_gnt0 !== 1'b1 || o_gnt1 !== 1'b0) begin n_fail++; $display("FAIL load_gnt: got %b%b want 10", o_gnt0, o_gnt1); end
    cycle();
    idle();
    #1;
    n_checks++; if (o_rvalid0 !== 1'b1 || o_rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_resp: got %b %h want 1 deadbeef", o_rvalid0, o_rdata0); end
    n_checks++; if (o_rvalid1 !== 1'b0) begin n_fail++; $display("FAIL load_rvalid1: got %b want 0", o_rvalid1); end
    cycle();
    n_checks++; if (o_rvalid0 !== 1'b0 || o_rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rdata_hold: got %b %h want 0 deadbeef", o_rvalid0, o_rdata0); end
  endtask

  task automatic test_both_after_reset();
    // Preload a word for port 1.
    idle();
    i_req1 = 1'b1; i_we1 = 1'b1; i_addr1 = 32'h20; i_wdata1 = 32'hCAFE0001;
    cycle();
    do_reset();
    i_req0 = 1'b1; i_addr0 = 32'h10;
    i_req1 = 1'b1; i_addr1 = 32'h20;
    #1;
    n_checks++; if (o_gnt0 !== 1'b1 || o_gnt1 !== 1'b0) begin n_fail++; $display("FAIL first_after_reset: got %b%b want 10", o_gnt0, o_gnt1); end
    cycle();
    i_req0 = 1'b0;
    #1;
    n_checks++; if (o_gnt1 !== 1'b1 || o_lsu_addr !== 32'h20) begin n_fail++; $display("FAIL p1_follows: got gnt1 %b addr %h want 1 00000020", o_gnt1, o_lsu_addr); end
    cycle();
    idle();
    #1;
    n_checks++; if (o_rvalid1 !== 1'b1 || o_rdata1 !== 32'hCAFE0001 || o_rvalid0 !== 1'b0) begin n_fail++; $display("FAIL p1_resp: got rv1 %b %h rv0 %b want 1 cafe0001 0", o_rvalid1, o_rdata1, o_rvalid0); end
    cycle();
  endtask

  task automatic test_contention();
    logic exp [12];
    exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    i_req0 = 1'b1; i_addr0 = 32'h10;
    i_req1 = 1'b1; i_addr1 = 32'h20;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_checks++; if (o_gnt1 !== exp[i] || o_gnt0 !== !exp[i]) begin n_fail++; $display("FAIL burst4_seq[%0d]: got %b%b want gnt1=%b", i, o_gnt0, o_gnt1, exp[i]); end
      n_checks++; if (gnt1_b !== 1'(i % 2) || gnt0_b !== 1'(1 - (i % 2))) begin n_fail++; $display("FAIL burst1_alt[%0d]: got %b%b want gnt1=%0d", i, gnt0_b, gnt1_b, i % 2); end
      if (i > 0) begin
        n_checks++; if (o_rvalid1 !== exp[i-1] || o_rvalid0 !== !exp[i-1]) begin n_fail++; $display("FAIL burst4_rvalid[%0d]: got %b%b want rv1=%b", i, o_rvalid0, o_rvalid1, exp[i-1]); end
      end
      cycle();
    end
    idle();
    cycle();
  endtask

  task automatic test_saturated();
    idle();
    cycle();
    i_req1 = 1'b1; i_addr1 = 32'h20;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++; if (o_gnt1 !== 1'b1) begin n_fail++; $display("FAIL stream1[%0d]: got %b want 1", i, o_gnt1); end
      cycle();
    end
    i_req0 = 1'b1; i_addr0 = 32'h10;
    #1;
    n_checks++; if (o_gnt0 !== 1'b1 || o_gnt1 !== 1'b0 || o_lsu_addr !== 32'h10) begin n_fail++; $display("FAIL saturated_yield: got %b%b addr %h want 10 00000010", o_gnt0, o_gnt1, o_lsu_addr); end
    cycle();
    idle();
    cycle();
    cycle();
  endtask

  task automatic test_store_no_resp();
    idle();
    i_req1 = 1'b1; i_we1 = 1'b1; i_addr1 = 32'h1000_0000; i_wdata1 = 32'h55;
    #1;
    n_checks++; if (o_gnt1 !== 1'b1 || o_lsu_wren !== 1'b1 || o_lsu_addr !== 32'h1000_0000 || o_st_data !== 32'h55) begin n_fail++; $display("FAIL store_drive: got gnt1 %b wren %b addr %h data %h want 1 1 10000000 00000055", o_gnt1, o_lsu_wren, o_lsu_addr, o_st_data); end
    cycle();
    idle();
    #1;
    n_checks++; if (o_lsu_wren !== 1'b0) begin n_fail++; $display("FAIL store_one_cycle: got wren %b want 0", o_lsu_wren); end
    n_checks++; if (ledr !== 32'h55) begin n_fail++; $display("FAIL store_ledr: got %h want 00000055", ledr); end
    n_checks++; if (o_rvalid1 !== 1'b0) begin n_fail++; $display("FAIL store_rvalid1: got %b want 0", o_rvalid1); end
    cycle();
  endtask

  task automatic test_reset_mid_load();
    idle();
    i_req0 = 1'b1; i_addr0 = 32'h10;
    #1;
    n_checks++; if (o_gnt0 !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt: got %b want 1", o_gnt0); end
    cycle();
    i_reset = 1'b1;
    i_req1 = 1'b1; i_addr1 = 32'h20;
    #1;
    n_checks++; if (o_gnt0 !== 1'b0 || o_gnt1 !== 1'b0 || o_lsu_wren !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got %b%b wren %b want 00 0", o_gnt0, o_gnt1, o_lsu_wren); end
    cycle();
    n_checks++; if (o_rvalid0 !== 1'b0 || o_gnt0 !== 1'b0 || o_gnt1 !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid: got rv0 %b gnt %b%b want 0 00", o_rvalid0, o_gnt0, o_gnt1); end
    i_reset = 1'b0;
    #1;
    n_checks++; if (o_gnt0 !== 1'b1 || o_gnt1 !== 1'b0) begin n_fail++; $display("FAIL midrst_after: got %b%b want 10", o_gnt0, o_gnt1); end
    cycle();
    idle();
    cycle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    ledr = '0;
    idle();
    i_reset = 1'b1;
    test_reset();
    test_single_load();
    test_both_after_reset();
    test_contention();
    test_saturated();
    test_store_no_resp();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Two-requester arbiter that shares the single load/store unit port between the core data port (port 0) and the debug/program-loader port (port 1). It uses round-robin arbitration with a bounded burst length, so one requester can hold the LSU for back-to-back beats without starving the other. It sits directly in front of `lsu`: it drives `lsu` address, store data and write enable, and returns registered load data to the winning requester.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MAX_BURST`, 4, maximum consecutive beats granted to one owner while the other port is requesting (legal range 1..15).

Ports:
- `i_clk`  in  1  clock.
- `i_reset`  in  1  reset, synchronous, active-high.
- `i_req0` / `i_req1`  in  1  request from port 0 / port 1.
- `i_we0` / `i_we1`  in  1  1 = store, 0 = load.
- `i_addr0` / `i_addr1`  in  ADDR_W  byte address.
- `i_wdata0` / `i_wdata1`  in  DATA_W  store data.
- `o_gnt0` / `o_gnt1`  out  1  beat accepted this cycle (combinational).
- `o_rvalid0` / `o_rvalid1`  out  1  load response valid.
- `o_rdata0` / `o_rdata1`  out  DATA_W  load response data.
- `o_lsu_addr`  out  ADDR_W  to `lsu` `i_lsu_addr`.
- `o_st_data`  out  DATA_W  to `lsu` `i_st_data`.
- `o_lsu_wren`  out  1  to `lsu` `i_lsu_wren`.
- `i_ld_data`  in  DATA_W  from `lsu` `o_ld_data` (combinational read).

## Operation
- Registered state:
  - `owner`: one of IDLE, OWN0, OWN1.
  - `cnt`: consecutive beats granted to the owner, saturating at MAX_BURST.
  - `last`: the port granted most recently.
- Winner selection each cycle (combinational, from registered state and current requests):
  - IDLE or no owner request, one port requesting: that port wins.
  - IDLE, both requesting: the port other than `last` wins. After reset, `last` = 1, so port 0 wins.
  - OWNx, `i_reqx` high, and (`cnt` < MAX_BURST or other port idle): x wins.
  - OWNx, `cnt` == MAX_BURST, other port requesting: the other port wins.
  - OWNx, `i_reqx` low, other port requesting: the other port wins.
  - No requests: no winner.
- Next state:
  - Winner w equal to the current owner: `cnt` = min(`cnt`+1, MAX_BURST).
  - Winner w differs from the current owner: `owner` = OWNw, `cnt` = 1.
  - In both cases `last` = w.
  - No winner: `owner` = IDLE, `cnt` = 0, `last` unchanged.
- `o_gntw` = 1 for the winner only. The two grants are never high together.
- LSU drive:
  - With a winner: the winner's addr/wdata are muxed out, and `o_lsu_wren` = winner's `we`.
  - With no winner: addr = 0, data = 0, wren = 0.
- Load response: a granted load on port x sets `o_rvalidx` = 1 on the next cycle, with `o_rdatax` = `i_ld_data` captured at the grant edge.
- `o_rdatax` holds its value until the next load response on port x.
- Stores produce no rvalid.
- Requester rules:
  - Hold addr/we/wdata stable while req is high without a grant.
  - Req may be dropped before a grant with no side effect.
  - A new beat may be presented in the cycle immediately after a grant.

## Timing
- Grant latency is 0 cycles: a grant is issued in the same cycle as the request when the port wins.
- A store commits in `lsu` at the rising edge that ends the grant cycle.
- A load returns data 1 cycle after its grant.
- Throughput is 1 beat per cycle in total, across both ports.
- Reset values:
  - `owner` = IDLE, `cnt` = 0, `last` = 1.
  - `o_rvalid0/1` = 0, `o_rdata0/1` = 0.
- While `i_reset` is high:
  - `o_gnt0/1` = 0, `o_lsu_wren` = 0, `o_lsu_addr` = 0, `o_st_data` = 0.
  - Requests are ignored.
- Reset mid-operation: a load granted in the cycle before reset still produces no rvalid after reset. The rvalid register is cleared by reset.
- Saturation edge case: while an owner keeps streaming alone, `cnt` stays at MAX_BURST. The other port therefore wins on the very first cycle it requests.
- MAX_BURST = 1 degenerates to strict alternation when both ports request.

## Structure
- Shared package `lsu_arb_pkg` holds:
  - `owner_e` enum {IDLE, OWN0, OWN1}.
  - `port_e` enum {P0, P1}.
  - `LSU_ARB_MAX_BURST_DEF` = 4.
- Optional sub-module `lsu_arb_pick`: purely combinational winner selection (state, reqs → winner, valid). The rest of the logic stays in `lsu_arbiter`.
- Expected size is about 150–250 lines of RTL, including the package.

## Test plan
1. **Single load.** Setup: port 0 writes 0xDEADBEEF to 0x10. Stimulus: port 0 reads 0x10 with port 1 idle. Required: `o_gnt0` = 1 in the same cycle; next cycle `o_rvalid0` = 1 and `o_rdata0` = 0xDEADBEEF; `o_rvalid1` stays 0.
2. **Both request after reset.** Stimulus: `i_req0` = `i_req1` = 1 in the first cycle after reset. Required: port 0 is granted first, then port 1 follows, per the burst rule.
3. **Contention with MAX_BURST = 4.** Stimulus: both ports request continuously for 12 cycles. Required grant sequence: 0,0,0,0,1,1,1,1,0,0,0,0.
4. **Saturated owner.** Stimulus: port 1 streams alone for 6 beats, then `i_req0` rises. Required: `o_gnt0` = 1 in that same cycle, and port 1 is stalled.
5. **Store with no response.** Stimulus: port 1 stores 0x55 to 0x1000_0000. Required: `o_lsu_wren` = 1 for one cycle; `lsu` `o_io_ledr` = 0x55 next cycle; `o_rvalid1` stays 0.
6. **Reset during a load.** Stimulus: `i_reset` rises in the cycle after port 0 is granted a load. Required: `o_rvalid0` = 0, both grants = 0, `o_lsu_wren` = 0; after reset with both ports requesting, port 0 is granted first.
